// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Streams 64-bit fetches from the
// instruction memory, splits each into two little-endian RISC-V words and
// buffers them with their PCs. Up to two instructions per cycle are handed to
// dual-issue decode. Branch redirect flushes the queue and restarts fetch.
module fetch_queue #(
    parameter logic [9:0] RESET_PC = 10'h000,
    parameter int         DEPTH    = 8
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    output logic        imem_re_o,
    output logic [9:0]  imem_addr_o,
    input  logic [63:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [9:0]  redirect_pc_i,
    input  logic [1:0]  deq_i,
    output logic        valid0_o,
    output logic [31:0] inst0_o,
    output logic [9:0]  pc0_o,
    output logic        valid1_o,
    output logic [31:0] inst1_o,
    output logic [9:0]  pc1_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
    // Issue is allowed while occupancy plus reserved slots leaves room for two more.
    localparam logic [CNT_W:0]   ISSUE_LIMIT = (CNT_W + 1)'(DEPTH - 2);

    // Registered state
    logic [9:0]       fetch_pc_reg;
    logic             inflight_reg;
    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;

    // Queue storage: one instruction word and its PC per entry
    logic [31:0] inst_mem [DEPTH];
    logic [9:0]  pc_mem   [DEPTH];

    // Combinational helpers
    logic [CNT_W:0]   used_slots;
    logic             issue;
    logic             resp;
    logic [1:0]       deq_req;
    logic [1:0]       deq_eff;
    logic [CNT_W-1:0] count_next;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;
    logic [PTR_W-1:0] tail_plus1;
    logic [PTR_W-1:0] head_plus1;
    logic [9:0]       resp_pc_a;
    logic [9:0]       resp_pc_b;
    logic [31:0]      inst_a;
    logic [31:0]      inst_b;

    // The low two redirect bits are word-offset bits that fetch ignores.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc_i[1:0];

    // Occupancy counts entries already queued plus two for a response still in flight.
    assign used_slots = {1'b0, count_reg} + (inflight_reg ? (CNT_W + 1)'(2) : '0);
    assign issue      = reset_n_i & ~redirect_i & (used_slots <= ISSUE_LIMIT);
    assign resp       = inflight_reg & ~redirect_i;

    assign imem_re_o   = issue;
    assign imem_addr_o = fetch_pc_reg;

    // fetch_pc already advanced by 8 when the request left, so step back for its PC.
    assign resp_pc_a = fetch_pc_reg - 10'd8;
    assign resp_pc_b = fetch_pc_reg - 10'd4;

    // Byte 0 sits in the top lane; each 32-bit word is assembled little-endian.
    assign inst_a = {imem_data_i[39:32], imem_data_i[47:40], imem_data_i[55:48], imem_data_i[63:56]};
    assign inst_b = {imem_data_i[7:0],   imem_data_i[15:8],  imem_data_i[23:16], imem_data_i[31:24]};

    assign tail_plus1 = tail_reg + PTR_W'(1);
    assign head_plus1 = head_reg + PTR_W'(1);

    // Clamp the decode request to 2 and to what the queue actually holds.
    always_comb begin
        deq_req = (deq_i == 2'd3) ? 2'd2 : deq_i;
        deq_eff = deq_req;
        if (count_reg == '0) begin
            deq_eff = 2'd0;
        end else if (count_reg == CNT_W'(1) && deq_req == 2'd2) begin
            deq_eff = 2'd1;
        end
    end

    // Next occupancy and pointers; redirect empties the queue outright.
    always_comb begin
        count_next = count_reg + (resp ? CNT_W'(2) : '0) - CNT_W'(deq_eff);
        head_next  = head_reg + PTR_W'(deq_eff);
        tail_next  = tail_reg + (resp ? PTR_W'(2) : '0);
        if (redirect_i) begin
            count_next = '0;
            head_next  = '0;
            tail_next  = '0;
        end
    end

    // Fetch PC, in-flight flag, occupancy and pointers.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            fetch_pc_reg <= RESET_PC;
            inflight_reg <= 1'b0;
            count_reg    <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
        end else begin
            if (redirect_i) begin
                fetch_pc_reg <= {redirect_pc_i[9:2], 2'b00};
            end else if (issue) begin
                fetch_pc_reg <= fetch_pc_reg + 10'd8;
            end
            inflight_reg <= issue;
            count_reg    <= count_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
        end
    end

    // Per-entry write port: instruction A lands at tail, instruction B at tail+1.
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
        // Capture this entry when a response targets its slot.
        always_ff @(posedge clock_i) begin
            if (resp && tail_reg == PTR_W'(gi)) begin
                inst_mem[gi] <= inst_a;
                pc_mem[gi]   <= resp_pc_a;
            end else if (resp && tail_plus1 == PTR_W'(gi)) begin
                inst_mem[gi] <= inst_b;
                pc_mem[gi]   <= resp_pc_b;
            end
        end
    end

    // Head view for decode, straight from queue registers.
    assign valid0_o = reset_n_i & (count_reg != '0);
    assign valid1_o = reset_n_i & (count_reg >= CNT_W'(2));
    assign inst0_o  = inst_mem[head_reg];
    assign pc0_o    = pc_mem[head_reg];
    assign inst1_o  = inst_mem[head_plus1];
    assign pc1_o    = pc_mem[head_plus1];

    // Issue throttling must keep occupancy within the queue.
    assert property (@(posedge clock_i) disable iff (!reset_n_i) count_reg <= DEPTH_C);

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch initiator for the simple instruction memory port: 10-bit byte address, read enable, 64-bit response one cycle later.
- Drives fetch requests, byte-swaps each 64-bit response into two little-endian 32-bit RISC-V instructions, and buffers them with their PCs in a small FIFO.
- Presents up to two instructions per cycle to the dual-issue decode stage.
- Supports decode backpressure and branch redirect.

Parameters:
- RESET_PC, 10'h000, fetch PC after reset; bits [1:0] must be 0.
- DEPTH, 8, queue capacity in instructions; power of two, at least 4.

Ports:
- clock_i  in  1  clock.
- reset_n_i  in  1  synchronous active-low reset.
- imem_re_o  out  1  memory read enable.
- imem_addr_o  out  10  memory byte address.
- imem_data_i  in  64  memory read data, valid the cycle after imem_re_o=1.
- redirect_i  in  1  flush the queue and restart fetch at redirect_pc_i.
- redirect_pc_i  in  10  redirect target; bits [1:0] ignored and treated as 0.
- deq_i  in  2  number of instructions decode consumes this cycle (0, 1 or 2).
- valid0_o  out  1  slot 0 holds a valid instruction.
- inst0_o  out  32  oldest instruction.
- pc0_o  out  10  PC of inst0_o.
- valid1_o  out  1  slot 1 holds a valid instruction.
- inst1_o  out  32  second-oldest instruction.
- pc1_o  out  10  PC of inst1_o.

Behaviour:
- Reset (reset_n_i=0 at a clock edge):
  - fetch_pc <= RESET_PC; queue count, pointers and inflight flag <= 0.
  - While reset_n_i=0: imem_re_o=0, valid0_o=0, valid1_o=0. inst/pc outputs are don't-care.
- Issue:
  - imem_re_o = reset_n_i & ~redirect_i & (DEPTH - count - 2*inflight >= 2). Combinational from registered state and redirect_i.
  - count is the registered value; same-cycle dequeues are not credited.
  - imem_addr_o = fetch_pc.
  - On issue: fetch_pc <= fetch_pc + 8, mod 1024; inflight <= 1. Otherwise inflight <= 0.
  - Back-to-back issue every cycle is permitted while there is space.
- Response (cycle after issue, inflight=1):
  - Byte k of imem_data_i is bits [63-8k -: 8].
  - Instruction A = {d[39:32], d[47:40], d[55:48], d[63:56]}, PC = issue address.
  - Instruction B = {d[7:0], d[15:8], d[23:16], d[31:24]}, PC = issue address + 4, mod 1024.
  - A then B are written at the tail. Each queue entry stores the 32-bit instruction and its 10-bit PC.
- Head outputs: driven from queue registers.
  - valid0_o = count >= 1; inst0_o/pc0_o = entry at head.
  - valid1_o = count >= 2; inst1_o/pc1_o = entry at head+1.
- Dequeue:
  - Effective dequeue = min(deq_i, count). deq_i=3 is treated as 2.
  - Head advances by the effective dequeue.
- Simultaneous events:
  - Enqueue of 2 and dequeue in the same cycle are legal; count <= count + 2*resp - deq_eff.
  - Head and tail pointers wrap modulo DEPTH.
  - Overflow cannot occur by construction; an assertion checks count <= DEPTH.
- Redirect (redirect_i=1 in cycle R):
  - Overrides deq_i and any response arriving in R; that response is discarded.
  - count <= 0; pointers <= 0; fetch_pc <= {redirect_pc_i[9:2], 2'b00}; no request is issued in R.
  - R+1: request at the target address. R+2: response. R+3: valid0_o=valid1_o=1.
- Address wrap: the fetch address and +4 wrap at 10 bits. A fetch at 0x3FC yields its instruction B from byte 0 with PC 0x000.
- Reset mid-operation: any in-flight response arriving in the cycle after reset deasserts is ignored, since inflight was cleared.
- Startup latency: C0 is the first cycle with reset_n_i=1. C0 issues address RESET_PC; C1 receives the response; C2 has valid0_o=valid1_o=1.

Test Plan:
- Reset release, RESET_PC=0, deq_i=2 each cycle -> imem_addr_o = 0x000, 0x008, 0x010 on C0, C1, C2; valids first high at C2; pc0/pc1 sequence 0/4, 8/12, 16/20.
- Bytes mem[0..7] = 13 05 10 00 93 05 20 00 -> inst0_o=0x00100513, pc0_o=0x000; inst1_o=0x00200593, pc1_o=0x004.
- deq_i=0 held after reset, DEPTH=8 -> exactly 4 requests (0x000, 0x008, 0x010, 0x018), then imem_re_o stays 0; count=8, outputs stable.
- deq_i=1 every cycle for 20 cycles -> pc0_o advances by 4 each cycle with no gaps or duplicates across pointer wrap; imem_re_o duty about 50%.
- Redirect to 0x105 in a cycle where a response arrives -> response dropped; valids low in R+1 and R+2; imem_addr_o=0x104 in R+1; at R+3 pc0_o=0x104, pc1_o=0x108.
- Redirect to 0x3FC -> request address 0x3FC; pc0_o=0x3FC with inst0_o from bytes 0x3FC..0x3FF; pc1_o=0x000 with bytes 0x000..0x003; next request address 0x004.
